// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared widths, FSM encodings and owner type for the memory port arbiter
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;
    localparam int PERF_W_DEF = 16;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
    localparam logic [2:0] FUNC3_WORD = 3'b010;
    typedef enum logic {OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side buses around the arbiter
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req, if_kill, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]        d_func3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              m_req, m_we;
    logic [2:0]        m_func3;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;

    modport slave (
        input  if_req, if_addr, if_kill, d_req, d_we, d_func3, d_addr, d_wdata, m_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_func3, m_addr, m_wdata
    );
    modport master (
        output if_req, if_addr, if_kill, d_req, d_we, d_func3, d_addr, d_wdata, m_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_func3, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: two-way selector, either fixed data priority or round-robin on the last grant
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_open,
    input  logic i_req_if,
    input  logic i_req_d,
    output logic o_gnt_if,
    output logic o_gnt_d
);
    owner_e r_last;
    logic   w_pick_d;

    // Round-robin ties go to whoever did not win last; reset leaves IF as last winner.
    assign w_pick_d = i_req_d & (DATA_PRIO | ~i_req_if | (r_last == OWN_IF));
    assign o_gnt_d  = i_open & w_pick_d;
    assign o_gnt_if = i_open & i_req_if & ~w_pick_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_last <= OWN_IF;
        else if (o_gnt_d) r_last <= OWN_D;
        else if (o_gnt_if) r_last <= OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store,
// one transaction in flight, combinational grant and response routing.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LAT       = 1,
    parameter int DATA_PRIO = 1,
    parameter int PERF_W    = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave io_bus,
    output logic [PERF_W-1:0] o_stall_cnt
);
    localparam int               CNT_W    = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    owner_e            r_owner;
    logic              r_we, r_kill;
    logic [PERF_W-1:0] r_stall;
    logic              w_resp, w_open, w_gnt_if, w_gnt_d, w_gnt, w_kill, w_if_rv, w_d_rv;

    assign w_resp = (r_state == ST_BUSY) && (r_cnt == CNT_ONE);
    // Reset gates the open window so no grant leaks out while rst_n is low.
    assign w_open = rst_n & ((r_state == ST_IDLE) | w_resp);
    assign w_gnt  = w_gnt_if | w_gnt_d;
    assign w_kill = r_kill | (io_bus.if_kill & (r_state == ST_BUSY) & (r_owner == OWN_IF));

    arb_pick #(.DATA_PRIO(DATA_PRIO != 0)) u_pick (
        .clk,
        .rst_n,
        .i_open   (w_open),
        .i_req_if (io_bus.if_req),
        .i_req_d  (io_bus.d_req),
        .o_gnt_if (w_gnt_if),
        .o_gnt_d  (w_gnt_d)
    );

    assign w_if_rv = w_resp & (r_owner == OWN_IF) & ~w_kill;
    assign w_d_rv  = w_resp & (r_owner == OWN_D);

    assign io_bus.if_gnt    = w_gnt_if;
    assign io_bus.d_gnt     = w_gnt_d;
    assign io_bus.m_req     = w_gnt;
    assign io_bus.m_we      = w_gnt_d & io_bus.d_we;
    assign io_bus.m_func3   = w_gnt_d ? io_bus.d_func3 : (w_gnt_if ? FUNC3_WORD : 3'b000);
    assign io_bus.m_addr    = w_gnt_d ? io_bus.d_addr : (w_gnt_if ? io_bus.if_addr : ADDR_W'(0));
    assign io_bus.m_wdata   = w_gnt_d ? io_bus.d_wdata : DATA_W'(0);
    assign io_bus.if_rvalid = w_if_rv;
    assign io_bus.d_rvalid  = w_d_rv;
    assign io_bus.if_rdata  = w_if_rv ? io_bus.m_rdata : DATA_W'(0);
    assign io_bus.d_rdata   = (w_d_rv & ~r_we) ? io_bus.m_rdata : DATA_W'(0);
    assign o_stall_cnt      = r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= OWN_IF;
            r_we    <= 1'b0;
            r_kill  <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_state <= ST_BUSY;
                r_cnt   <= CNT_LOAD;
                r_owner <= w_gnt_d ? OWN_D : OWN_IF;
                r_we    <= w_gnt_d & io_bus.d_we;
            end else if (w_resp) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            // A kill only ever covers the transaction completing now, never the next grant.
            r_kill <= w_resp ? 1'b0 : w_kill;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_stall <= '0;
        else if (io_bus.if_req & ~w_gnt_if & !(&r_stall)) r_stall <= r_stall + PERF_W'(1);
endmodule
